divider: RTL and testbench
==========================

# divider

Iterative radix-2 restoring divider for the RV32M division group (div, divu, rem, remu), the counterpart to the pipelined multiplier in the execute-stage M-extension unit. Accepts one operation per start pulse, runs a fixed 32-step shift/subtract loop, and returns a 32-bit quotient or remainder with a single-cycle done pulse. The execute stage stalls on busy.

## Interface
- No parameters; data width fixed at 32.
- clk  in  1  sole clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- flush  in  1  abort in-flight operation (pipeline flush).
- rs1_data  in  32  dividend.
- rs2_data  in  32  divisor.
- funct3  in  m_funct3  operation; only div, divu, rem, remu are accepted.
- busy  out  1  high from the cycle after acceptance until done.
- done  out  1  one-cycle pulse; div_out valid.
- div_out  out  32  result, held until the next accepted start.

## Operation
- States: IDLE, DIV, FIX, DONE.
- IDLE: start=1 with a division funct3 latches the operands, funct3, sign flags, abs values (signed ops only), count=31, and moves to DIV. start with a mul-class funct3 is ignored and produces no done.
- DIV: each cycle shifts {rem, quo} left by 1, trial-subtracts the abs divisor from the 33-bit partial remainder, and keeps the result and sets the quotient bit if it is non-negative. Exits to FIX when count==0.
- FIX: negates the quotient if the sign flags differ (signed div). Negates the remainder if the dividend was negative (signed rem). Selects quotient (div/divu) or remainder (rem/remu) into the div_out register.
- DONE: done=1 for one cycle, then IDLE.
- Divide by zero: quotient=0xFFFFFFFF, remainder=dividend, for both signed and unsigned.
- Signed overflow (0x80000000 / -1): quotient=0x80000000, remainder=0.
- Abs of 0x80000000 is treated as unsigned 0x80000000.
- flush: in any state, returns to IDLE next cycle. busy=0, no done, div_out unchanged. If flush and start occur in the same cycle in IDLE, flush wins and the start is dropped.
- start while busy is ignored.
- Reset values: state=IDLE, busy=0, done=0, div_out=0, all internal registers 0. Reset mid-operation aborts with no done.

## Timing
- Start accepted in cycle T: busy=1 during T+1..T+33, DIV during T+1..T+32, FIX at T+33, done=1 and div_out valid at T+34. Latency is 34 cycles.
- busy drops in the same cycle done rises.
- The next start is accepted at T+35 at the earliest (IDLE), giving a throughput of 1 op per 35 cycles.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- DIV_FAST_SPECIAL_EN defined: divide-by-zero and signed overflow are detected at acceptance and go straight to DONE with the architectural result. done arrives at T+2 and busy is high only at T+1.
- Not defined: these cases run the full 34-cycle loop and produce identical results.
- All other timing is unchanged.

## Structure
- Shared package m_extension: m_funct3 enum (reused from the multiplier), divider state enum, and constants DIV_ZERO_QUO=32'hFFFFFFFF and INT_MIN=32'h80000000.
- One sub-module: div_step, a combinational single-iteration shift/trial-subtract (33-bit partial remainder in/out, quotient bit out), instantiated once inside the DIV datapath.

## Test plan
- divu 100 / 7 -> done at T+34, div_out=14. remu 100 / 7 -> 2.
- div -7 / 2 -> 0xFFFFFFFD (-3). rem -7 / 2 -> 0xFFFFFFFF (-1). rem 7 / -2 -> 1.
- div 5 / 0 -> 0xFFFFFFFF. rem 5 / 0 -> 5. Both at T+34 without the macro, T+2 with it.
- div 0x80000000 / 0xFFFFFFFF -> 0x80000000. rem of the same -> 0.
- Start divu 10/3, then assert flush at T+10 -> no done, IDLE at T+11. A new start at T+11 completes normally. A second start asserted during busy is ignored.
- rst low at T+20 of an active op -> busy=0, done=0 and div_out=0 immediately. After release, start with funct3=mul -> no done and busy stays 0.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared M-extension definitions: funct3 encodings, divider state encoding and
// the architectural constants for the divide-by-zero and signed-overflow cases.
package m_extension;

   typedef enum logic [2:0] {
      F3_MUL    = 3'b000,
      F3_MULH   = 3'b001,
      F3_MULHSU = 3'b010,
      F3_MULHU  = 3'b011,
      F3_DIV    = 3'b100,
      F3_DIVU   = 3'b101,
      F3_REM    = 3'b110,
      F3_REMU   = 3'b111
   } m_funct3;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DIV  = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } div_state_e;

   localparam logic [31:0] DIV_ZERO_QUO = 32'hFFFF_FFFF;
   localparam logic [31:0] INT_MIN      = 32'h8000_0000;

   // The division group is exactly the funct3 codes with bit 2 set.
   function automatic logic is_div_op(input m_funct3 f);
      return f[2];
   endfunction

   function automatic logic is_signed_op(input m_funct3 f);
      return (f == F3_DIV) || (f == F3_REM);
   endfunction

endpackage

// File: rtl/divider_step.sv
// One restoring-division iteration: shift the partial remainder left, bring in
// the next dividend bit, trial-subtract the divisor and keep it if non-negative.
module div_step (
   input  logic [32:0] rem_in,
   input  logic        bit_in,
   input  logic [31:0] divisor,
   output logic [32:0] rem_out,
   output logic        q_bit
);

   logic [33:0] shifted;
   logic [33:0] diff;

   assign shifted = {rem_in, bit_in};
   assign diff    = shifted - {2'b00, divisor};
   assign q_bit   = ~diff[33];
   assign rem_out = q_bit ? diff[32:0] : shifted[32:0];

endmodule

// File: rtl/divider.sv
// Iterative radix-2 restoring divider for div/divu/rem/remu (34-cycle latency).
// Optional build macro DIV_FAST_SPECIAL_EN short-cuts divide-by-zero and overflow.
import m_extension::*;

module divider (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        flush,
   input  logic [31:0] rs1_data,
   input  logic [31:0] rs2_data,
   input  m_funct3     funct3,
   output logic        busy,
   output logic        done,
   output logic [31:0] div_out,
   output logic [1:0]  state_dbg
);

   div_state_e  state;
   m_funct3     op;
   logic [4:0]  count;
   logic [32:0] rem_r;
   logic [31:0] quo_r;
   logic [31:0] dvsr_abs;
   logic [31:0] dividend;
   logic        neg_q;
   logic        neg_r;
   logic        div_zero;

   logic        sgn_in;
   logic [31:0] abs_a;
   logic [31:0] abs_b;
   logic        special_in;
   logic [32:0] step_rem;
   logic        step_q;
   logic [31:0] q_fix;
   logic [31:0] r_fix;
   logic [31:0] result;

   // Negating INT_MIN wraps back to 0x80000000, which is the wanted unsigned magnitude.
   assign sgn_in     = is_signed_op(funct3);
   assign abs_a      = (sgn_in && rs1_data[31]) ? -rs1_data : rs1_data;
   assign abs_b      = (sgn_in && rs2_data[31]) ? -rs2_data : rs2_data;
   assign special_in = (rs2_data == 32'd0) ||
                       (sgn_in && rs1_data == INT_MIN && rs2_data == 32'hFFFF_FFFF);

   div_step u_step (
      .rem_in  (rem_r),
      .bit_in  (quo_r[31]),
      .divisor (dvsr_abs),
      .rem_out (step_rem),
      .q_bit   (step_q)
   );

   assign q_fix  = div_zero ? DIV_ZERO_QUO : (neg_q ? -quo_r : quo_r);
   assign r_fix  = div_zero ? dividend : (neg_r ? -rem_r[31:0] : rem_r[31:0]);
   assign result = (op == F3_DIV || op == F3_DIVU) ? q_fix : r_fix;

   assign state_dbg = state;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_IDLE;
         op       <= F3_MUL;
         count    <= 5'd0;
         rem_r    <= 33'd0;
         quo_r    <= 32'd0;
         dvsr_abs <= 32'd0;
         dividend <= 32'd0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         div_zero <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         div_out  <= 32'd0;
      end else if (flush) begin
         state <= S_IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               done <= 1'b0;
               if (start && is_div_op(funct3)) begin
                  op       <= funct3;
                  dividend <= rs1_data;
                  neg_q    <= sgn_in && (rs1_data[31] ^ rs2_data[31]);
                  neg_r    <= sgn_in && rs1_data[31];
                  div_zero <= (rs2_data == 32'd0);
                  quo_r    <= abs_a;
                  rem_r    <= 33'd0;
                  dvsr_abs <= abs_b;
                  count    <= 5'd31;
                  busy     <= 1'b1;
`ifdef DIV_FAST_SPECIAL_EN
                  // Overflow already has quo=INT_MIN, rem=0; zero divisor is patched in FIX.
                  state    <= special_in ? S_FIX : S_DIV;
`else
                  state    <= S_DIV;
`endif
               end
            end
            S_DIV: begin
               rem_r <= step_rem;
               quo_r <= {quo_r[30:0], step_q};
               count <= count - 5'd1;
               if (count == 5'd0) state <= S_FIX;
            end
            S_FIX: begin
               div_out <= result;
               busy    <= 1'b0;
               done    <= 1'b1;
               state   <= S_DONE;
            end
            S_DONE: begin
               done  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifndef DIV_FAST_SPECIAL_EN
   logic unused_special;
   assign unused_special = special_in;
`endif

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for the divider: scoreboard of expected results, latency,
// busy/done timing, flush, mid-operation reset and ignored starts.
import m_extension::*;

module tb_divider;

   logic        clk;
   logic        rst;
   logic        start;
   logic        flush;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   m_funct3     funct3;
   logic        busy;
   logic        done;
   logic [31:0] div_out;
   logic [1:0]  state_dbg;

   logic [31:0] exp_q[$];
   logic [31:0] last_exp;
   int          checks;
   int          errors;

   divider dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .flush     (flush),
      .rs1_data  (rs1_data),
      .rs2_data  (rs2_data),
      .funct3    (funct3),
      .busy      (busy),
      .done      (done),
      .div_out   (div_out),
      .state_dbg (state_dbg)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   // ---------------- reference model ----------------
   function automatic logic [31:0] model(input m_funct3 f, input logic [31:0] a, input logic [31:0] b);
      logic signed [31:0] sa;
      logic signed [31:0] sb;
      logic [31:0] q;
      logic [31:0] r;
      logic        sg;
      sa = a;
      sb = b;
      sg = (f == F3_DIV) || (f == F3_REM);
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF;
         r = a;
      end else if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = 32'h8000_0000;
         r = 32'd0;
      end else if (sg) begin
         q = sa / sb;
         r = sa % sb;
      end else begin
         q = a / b;
         r = a % b;
      end
      return (f == F3_DIV || f == F3_DIVU) ? q : r;
   endfunction

   function automatic int exp_lat(input m_funct3 f, input logic [31:0] a, input logic [31:0] b);
      int lat;
      lat = 34;
`ifdef DIV_FAST_SPECIAL_EN
      if (b == 32'd0 ||
          (((f == F3_DIV) || (f == F3_REM)) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))
         lat = 2;
`endif
      return lat;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic issue(input m_funct3 f, input logic [31:0] a, input logic [31:0] b);
      start    = 1'b1;
      funct3   = f;
      rs1_data = a;
      rs2_data = b;
   endtask

   // Waits from the acceptance edge for done; checks latency, busy window and result.
   task automatic wait_done(input string name, input int lat, input bit stray);
      int          n;
      bit          got;
      bit          busy_ok;
      logic [31:0] exp;
      @(posedge clk);
      n = 0;
      got = 1'b0;
      busy_ok = 1'b1;
      while (!got && n < 60) begin
         @(negedge clk);
         n++;
         if (n == 1) start = 1'b0;
         if (stray && n == 5) issue(F3_DIVU, 32'h0000_1234, 32'd3);
         if (stray && n == 6) start = 1'b0;
         if (done === 1'b1) got = 1'b1;
         else if (busy !== 1'b1) busy_ok = 1'b0;
      end
      exp = exp_q.pop_front();
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL %s timeout: got no done after %0d cycles, required done", name, n);
      end else begin
         checks++;
         if (n != lat) begin
            errors++;
            $display("FAIL %s latency: got %0d required %0d", name, n, lat);
         end
         checks++;
         if (!busy_ok || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy window: got busy_ok=%0b busy_at_done=%b required 1/0", name, busy_ok, busy);
         end
         checks++;
         if (div_out !== exp) begin
            errors++;
            $display("FAIL %s result: got %h required %h", name, div_out, exp);
         end
         last_exp = exp;
      end
      @(posedge clk);
   endtask

   task automatic run_op(input string name, input m_funct3 f, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      issue(f, a, b);
      exp_q.push_back(model(f, a, b));
      wait_done(name, exp_lat(f, a, b), 1'b0);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      rst = 1'b0;
      start = 1'b0;
      flush = 1'b0;
      funct3 = F3_MUL;
      rs1_data = 32'd0;
      rs2_data = 32'd0;
      last_exp = 32'd0;
      repeat (3) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || div_out !== 32'd0 || state_dbg !== 2'd0) begin
         errors++;
         $display("FAIL reset_state: got busy=%b done=%b div_out=%h state=%0d required 0/0/0/0",
                  busy, done, div_out, state_dbg);
      end
      rst = 1'b1;
   endtask

   task automatic test_unsigned;
      run_op("divu_100_7", F3_DIVU, 32'd100, 32'd7);
      run_op("remu_100_7", F3_REMU, 32'd100, 32'd7);
      run_op("divu_big", F3_DIVU, 32'hFFFF_FFFF, 32'd1);
      run_op("remu_big", F3_REMU, 32'hFFFF_FFFE, 32'hFFFF_FFFF);
      for (int i = 0; i < 4; i++) begin
         run_op("divu_rand", F3_DIVU, $urandom, $urandom_range(1, 1000));
         run_op("remu_rand", F3_REMU, $urandom, $urandom);
      end
   endtask

   task automatic test_signed;
      run_op("div_m7_2", F3_DIV, 32'hFFFF_FFF9, 32'd2);
      run_op("rem_m7_2", F3_REM, 32'hFFFF_FFF9, 32'd2);
      run_op("rem_7_m2", F3_REM, 32'd7, 32'hFFFF_FFFE);
      run_op("div_m100_m7", F3_DIV, 32'hFFFF_FF9C, 32'hFFFF_FFF9);
      run_op("div_intmin_2", F3_DIV, 32'h8000_0000, 32'd2);
      for (int i = 0; i < 4; i++) begin
         run_op("div_rand", F3_DIV, $urandom, $urandom_range(1, 50000) - 25000);
         run_op("rem_rand", F3_REM, $urandom, $urandom);
      end
   endtask

   task automatic test_div_zero;
      run_op("div_5_0", F3_DIV, 32'd5, 32'd0);
      run_op("rem_5_0", F3_REM, 32'd5, 32'd0);
      run_op("div_m5_0", F3_DIV, 32'hFFFF_FFFB, 32'd0);
      run_op("divu_x_0", F3_DIVU, 32'hDEAD_BEEF, 32'd0);
      run_op("remu_x_0", F3_REMU, 32'hDEAD_BEEF, 32'd0);
   endtask

   task automatic test_overflow;
      run_op("div_ovf", F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op("rem_ovf", F3_REM, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op("divu_no_ovf", F3_DIVU, 32'h8000_0000, 32'hFFFF_FFFF);
   endtask

   task automatic test_flush;
      int n;
      bit seen_done;
      seen_done = 1'b0;
      @(negedge clk);
      issue(F3_DIVU, 32'd10, 32'd3);
      @(posedge clk);
      for (n = 1; n <= 11; n++) begin
         @(negedge clk);
         if (n == 1) start = 1'b0;
         if (done === 1'b1) seen_done = 1'b1;
         if (n == 10) flush = 1'b1;
      end
      checks++;
      if (state_dbg !== 2'd0 || busy !== 1'b0 || seen_done || div_out !== last_exp) begin
         errors++;
         $display("FAIL flush_abort: got state=%0d busy=%b done_seen=%0b div_out=%h required 0/0/0/%h",
                  state_dbg, busy, seen_done, div_out, last_exp);
      end
      flush = 1'b0;
      issue(F3_DIVU, 32'd10, 32'd3);
      exp_q.push_back(model(F3_DIVU, 32'd10, 32'd3));
      wait_done("divu_after_flush", 34, 1'b0);
      // Flush and start together in IDLE: the start must be dropped.
      @(negedge clk);
      issue(F3_DIVU, 32'd9, 32'd2);
      flush = 1'b1;
      @(negedge clk);
      start = 1'b0;
      flush = 1'b0;
      seen_done = 1'b0;
      checks++;
      if (state_dbg !== 2'd0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL flush_start_same: got state=%0d busy=%b required 0/0", state_dbg, busy);
      end
      repeat (40) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
      end
      checks++;
      if (seen_done) begin
         errors++;
         $display("FAIL flush_start_activity: got activity=1 required 0");
      end
   endtask

   task automatic test_back_to_back;
      bit extra;
      extra = 1'b0;
      @(negedge clk);
      issue(F3_REMU, 32'd1000, 32'd33);
      exp_q.push_back(model(F3_REMU, 32'd1000, 32'd33));
      wait_done("b2b_first_stray", 34, 1'b1);
      run_op("b2b_second", F3_DIV, 32'hFFFF_FC18, 32'd7);
      repeat (40) begin
         @(negedge clk);
         if (done === 1'b1) extra = 1'b1;
      end
      checks++;
      if (extra || exp_q.size() != 0) begin
         errors++;
         $display("FAIL b2b_stray_ignored: got extra_done=%0b queue=%0d required 0/0", extra, exp_q.size());
      end
   endtask

   task automatic test_reset_mid;
      bit act;
      act = 1'b0;
      @(negedge clk);
      issue(F3_DIVU, 32'd100, 32'd7);
      exp_q.push_back(model(F3_DIVU, 32'd100, 32'd7));
      @(posedge clk);
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (n == 1) start = 1'b0;
      end
      rst = 1'b0;
      #1;
      void'(exp_q.pop_back());
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || div_out !== 32'd0) begin
         errors++;
         $display("FAIL reset_mid: got busy=%b done=%b div_out=%h required 0/0/0", busy, done, div_out);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      issue(F3_MUL, 32'd3, 32'd4);
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (n == 1) start = 1'b0;
         if (done === 1'b1 || busy === 1'b1) act = 1'b1;
      end
      checks++;
      if (act || state_dbg !== 2'd0) begin
         errors++;
         $display("FAIL mul_ignored: got activity=%0b state=%0d required 0/0", act, state_dbg);
      end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_unsigned();
      test_signed();
      test_div_zero();
      test_overflow();
      test_flush();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
